// File: rtl/photo_frame_capture.sv
// photo_frame_capture
// Drives the photo tape reader relays and conditions the five photocell lines.
// Assembles each punched frame into a 5-bit code and offers it to the
// typewriter logic over a valid/ready handshake. Also reports the stop code,
// end of tape and frame overrun.
module photo_frame_capture #(
    parameter int         DEB_CLKS   = 4,
    parameter int         GAP_CLKS   = 16,
    parameter int         TIMEOUT_MS = 2000,
    parameter logic [4:0] STOP_CODE  = 5'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       PL6_PHOTO1,
    input  logic       PL6_PHOTO2,
    input  logic       PL6_PHOTO3,
    input  logic       PL6_PHOTO4,
    input  logic       PL6_PHOTO5,
    input  logic       start_fwd,
    input  logic       start_rev,
    input  logic       stop,
    output logic       PL6_PHOTO_TAPE_FWD,
    output logic       PL6_PHOTO_TAPE_REV,
    output logic [4:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       stop_seen,
    output logic       tape_end,
    output logic       overrun,
    output logic       busy
);

    localparam int DCW = $clog2(DEB_CLKS + 1);
    localparam int GCW = $clog2(GAP_CLKS + 1);

    localparam logic [DCW-1:0] DEB_ZERO = {DCW{1'b0}};
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CLKS - 1);
    localparam logic [GCW-1:0] GAP_ZERO = {GCW{1'b0}};
    localparam logic [GCW-1:0] GAP_ONE  = GCW'(1);
    localparam logic [GCW-1:0] GAP_MAX  = GCW'(GAP_CLKS);
    localparam logic [10:0]    TO_MAX   = 11'(TIMEOUT_MS);
    localparam logic [10:0]    TO_LAST  = 11'(TIMEOUT_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_FWD = 2'd1,
        ST_FRAME   = 2'd2,
        ST_RUN_REV = 2'd3
    } state_t;

    // Input conditioning
    logic [4:0]     photo_raw_s;
    logic [4:0]     sync1_r;
    logic [4:0]     sync2_r;
    logic [4:0]     deb_r;
    logic [DCW-1:0] deb_cnt_r [0:4];
    logic           any_hole_s;

    // Control and datapath
    state_t         state_r;
    state_t         state_next_s;
    logic [10:0]    to_cnt_r;
    logic [GCW-1:0] gap_r;
    logic [4:0]     acc_r;

    logic           buf_free_s;
    logic           load_s;
    logic           ovr_set_s;
    logic           ovr_clr_s;
    logic           tape_end_s;
    logic           stop_seen_s;
    logic           to_clr_s;
    logic           to_inc_s;
    logic           acc_load_s;

    // Registered outputs
    logic           fwd_r;
    logic           rev_r;
    logic [4:0]     frame_data_r;
    logic           frame_valid_r;
    logic           stop_seen_r;
    logic           tape_end_r;
    logic           overrun_r;
    logic           busy_r;

    assign photo_raw_s = {PL6_PHOTO5, PL6_PHOTO4, PL6_PHOTO3, PL6_PHOTO2, PL6_PHOTO1};
    assign any_hole_s  = |deb_r;

    // Two-flop synchronizer followed by a per-line debouncer that flips only
    // after DEB_CLKS consecutive samples disagree with the current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 5'b0;
            sync2_r <= 5'b0;
            deb_r   <= 5'b0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_r[i] <= DEB_ZERO;
            end
        end else begin
            sync1_r <= photo_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 5; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= DEB_ZERO;
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_r[i] <= DEB_ZERO;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        ovr_set_s    = 1'b0;
        ovr_clr_s    = 1'b0;
        tape_end_s   = 1'b0;
        stop_seen_s  = 1'b0;
        to_clr_s     = 1'b0;
        to_inc_s     = 1'b0;
        acc_load_s   = 1'b0;
        // The buffer can take a new frame if it is empty or being drained now.
        buf_free_s   = (!frame_valid_r) || frame_ready;

        case (state_r)
            ST_IDLE: begin
                if (start_fwd && !start_rev) begin
                    state_next_s = ST_RUN_FWD;
                    ovr_clr_s    = 1'b1;
                    to_clr_s     = 1'b1;
                end else if (start_rev && !start_fwd) begin
                    state_next_s = ST_RUN_REV;
                    to_clr_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_RUN_FWD: begin
                if (stop) begin
                    state_next_s = ST_IDLE;
                end else if (any_hole_s) begin
                    state_next_s = ST_FRAME;
                    acc_load_s   = 1'b1;
                end else if (tick_ms) begin
                    to_inc_s = 1'b1;
                    if (to_cnt_r >= TO_LAST) begin
                        state_next_s = ST_IDLE;
                        tape_end_s   = 1'b1;
                    end else begin
                        state_next_s = ST_RUN_FWD;
                    end
                end else begin
                    state_next_s = ST_RUN_FWD;
                end
            end

            ST_FRAME: begin
                if (stop) begin
                    state_next_s = ST_IDLE;
                end else if (gap_r == GAP_MAX) begin
                    if (buf_free_s) begin
                        load_s = 1'b1;
                    end else begin
                        ovr_set_s = 1'b1;
                    end
                    if (acc_r == STOP_CODE) begin
                        state_next_s = ST_IDLE;
                        stop_seen_s  = buf_free_s;
                    end else begin
                        state_next_s = ST_RUN_FWD;
                        to_clr_s     = 1'b1;
                    end
                end else begin
                    state_next_s = ST_FRAME;
                end
            end

            ST_RUN_REV: begin
                if (stop) begin
                    state_next_s = ST_IDLE;
                end else if (any_hole_s) begin
                    state_next_s = ST_RUN_REV;
                    to_clr_s     = 1'b1;
                end else if (tick_ms) begin
                    to_inc_s = 1'b1;
                    if (to_cnt_r >= TO_LAST) begin
                        state_next_s = ST_IDLE;
                        tape_end_s   = 1'b1;
                    end else begin
                        state_next_s = ST_RUN_REV;
                    end
                end else begin
                    state_next_s = ST_RUN_REV;
                end
            end

            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Millisecond timeout counter, saturating at TIMEOUT_MS.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r <= 11'd0;
        end else if (to_clr_s) begin
            to_cnt_r <= 11'd0;
        end else if (to_inc_s && (to_cnt_r < TO_MAX)) begin
            to_cnt_r <= to_cnt_r + 11'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Frame accumulator and inter-frame gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 5'b0;
            gap_r <= GAP_ZERO;
        end else if (acc_load_s) begin
            acc_r <= deb_r;
            gap_r <= GAP_ZERO;
        end else if (state_r == ST_FRAME) begin
            acc_r <= acc_r | deb_r;
            if (any_hole_s) begin
                gap_r <= GAP_ZERO;
            end else if (gap_r < GAP_MAX) begin
                gap_r <= gap_r + GAP_ONE;
            end else begin
                gap_r <= gap_r;
            end
        end else begin
            acc_r <= acc_r;
            gap_r <= gap_r;
        end
    end

    // Output registers. Relay and busy levels follow the next state so they
    // change on the same edge as the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_r         <= 1'b0;
            rev_r         <= 1'b0;
            busy_r        <= 1'b0;
            frame_data_r  <= 5'b0;
            frame_valid_r <= 1'b0;
            stop_seen_r   <= 1'b0;
            tape_end_r    <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            fwd_r       <= (state_next_s == ST_RUN_FWD) || (state_next_s == ST_FRAME);
            rev_r       <= (state_next_s == ST_RUN_REV);
            busy_r      <= (state_next_s != ST_IDLE);
            stop_seen_r <= stop_seen_s;
            tape_end_r  <= tape_end_s;

            if (load_s) begin
                frame_data_r  <= acc_r;
                frame_valid_r <= 1'b1;
            end else if (frame_valid_r && frame_ready) begin
                frame_valid_r <= 1'b0;
            end else begin
                frame_valid_r <= frame_valid_r;
            end

            if (ovr_clr_s) begin
                overrun_r <= 1'b0;
            end else if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign PL6_PHOTO_TAPE_FWD = fwd_r;
    assign PL6_PHOTO_TAPE_REV = rev_r;
    assign frame_data         = frame_data_r;
    assign frame_valid        = frame_valid_r;
    assign stop_seen          = stop_seen_r;
    assign tape_end           = tape_end_r;
    assign overrun            = overrun_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_photo_frame_capture.sv
// Directed testbench for photo_frame_capture.
module tb_photo_frame_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_ms;
    logic [4:0] photo;
    logic       start_fwd;
    logic       start_rev;
    logic       stop;
    logic       frame_ready;
    logic       fwd;
    logic       rev;
    logic [4:0] frame_data;
    logic       frame_valid;
    logic       stop_seen;
    logic       tape_end;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    photo_frame_capture dut (
        .clk                (clk),
        .rst                (rst),
        .tick_ms            (tick_ms),
        .PL6_PHOTO1         (photo[0]),
        .PL6_PHOTO2         (photo[1]),
        .PL6_PHOTO3         (photo[2]),
        .PL6_PHOTO4         (photo[3]),
        .PL6_PHOTO5         (photo[4]),
        .start_fwd          (start_fwd),
        .start_rev          (start_rev),
        .stop               (stop),
        .PL6_PHOTO_TAPE_FWD (fwd),
        .PL6_PHOTO_TAPE_REV (rev),
        .frame_data         (frame_data),
        .frame_valid        (frame_valid),
        .frame_ready        (frame_ready),
        .stop_seen          (stop_seen),
        .tape_end           (tape_end),
        .overrun            (overrun),
        .busy               (busy)
    );

    task step();
        @(posedge clk);
        #1;
    endtask

    task pulse_start_fwd();
        start_fwd = 1'b1;
        step();
        start_fwd = 1'b0;
    endtask

    task pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task send_frame(input logic [4:0] code, input int hold);
        photo = code;
        repeat (hold) step();
        photo = 5'b0;
    endtask

    task wait_valid(input int max, output int cyc);
        cyc = 0;
        while (frame_valid !== 1'b1 && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    task drain();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({fwd, rev, frame_data, frame_valid, stop_seen, tape_end, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000000000",
                     {fwd, rev, frame_data, frame_valid, stop_seen, tape_end, overrun, busy});
        end
        rst = 1'b0;
        step();
    endtask

    task test_single_frame();
        int cyc;
        pulse_start_fwd();
        checks++;
        if (fwd !== 1'b1 || busy !== 1'b1 || rev !== 1'b0) begin
            errors++;
            $display("FAIL start_fwd_relay: fwd=%b busy=%b rev=%b required 1 1 0", fwd, busy, rev);
        end
        photo = 5'b01101;
        repeat (40) step();
        photo = 5'b0;
        wait_valid(100, cyc);
        checks++;
        if (frame_valid !== 1'b1 || (40 + cyc) !== 63) begin
            errors++;
            $display("FAIL frame_latency: valid=%b clocks=%0d required valid=1 clocks=63", frame_valid, 40 + cyc);
        end
        checks++;
        if (frame_data !== 5'h0D) begin
            errors++;
            $display("FAIL frame_data_0d: got %h required 0d", frame_data);
        end
        drain();
        checks++;
        if (frame_valid !== 1'b0 || fwd !== 1'b1) begin
            errors++;
            $display("FAIL handshake_clear: valid=%b fwd=%b required 0 1", frame_valid, fwd);
        end
    endtask

    task test_stop_code();
        int cyc;
        frame_ready = 1'b1;
        send_frame(5'h03, 10);
        wait_valid(100, cyc);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 5'h03 || stop_seen !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_03: valid=%b data=%h stop_seen=%b required 1 03 0",
                     frame_valid, frame_data, stop_seen);
        end
        step();
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_taken: valid=%b required 0", frame_valid);
        end
        send_frame(5'h10, 10);
        wait_valid(100, cyc);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 5'h10 || stop_seen !== 1'b1 ||
            fwd !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_frame: valid=%b data=%h stop_seen=%b fwd=%b busy=%b required 1 10 1 0 0",
                     frame_valid, frame_data, stop_seen, fwd, busy);
        end
        step();
        checks++;
        if (stop_seen !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_seen_pulse: stop_seen=%b valid=%b required 0 0", stop_seen, frame_valid);
        end
        frame_ready = 1'b0;
    endtask

    task test_overrun();
        int cyc;
        pulse_start_fwd();
        send_frame(5'h03, 10);
        wait_valid(100, cyc);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 5'h03 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: valid=%b data=%h overrun=%b required 1 03 0",
                     frame_valid, frame_data, overrun);
        end
        send_frame(5'h05, 10);
        cyc = 0;
        while (overrun !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        checks++;
        if (overrun !== 1'b1 || frame_data !== 5'h03 || frame_valid !== 1'b1 || fwd !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b data=%h valid=%b fwd=%b required 1 03 1 1",
                     overrun, frame_data, frame_valid, fwd);
        end
        pulse_stop();
        checks++;
        if (fwd !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_relay: fwd=%b busy=%b required 0 0", fwd, busy);
        end
        pulse_start_fwd();
        checks++;
        if (overrun !== 1'b0 || fwd !== 1'b1 || frame_valid !== 1'b1 || frame_data !== 5'h03) begin
            errors++;
            $display("FAIL overrun_clear: overrun=%b fwd=%b valid=%b data=%h required 0 1 1 03",
                     overrun, fwd, frame_valid, frame_data);
        end
        drain();
    endtask

    task test_glitch();
        int cyc;
        photo = 5'b00100;
        repeat (2) step();
        photo = 5'b0;
        repeat (40) step();
        checks++;
        if (frame_valid !== 1'b0 || fwd !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_ignored: valid=%b fwd=%b busy=%b required 0 1 1", frame_valid, fwd, busy);
        end
        send_frame(5'h01, 10);
        wait_valid(100, cyc);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 5'h01) begin
            errors++;
            $display("FAIL after_glitch_frame: valid=%b data=%h required 1 01", frame_valid, frame_data);
        end
        drain();
    endtask

    task test_timeout();
        logic relay;
        pulse_stop();
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin
                pulse_start_fwd();
            end else begin
                start_rev = 1'b1;
                step();
                start_rev = 1'b0;
            end
            relay = (m == 0) ? fwd : rev;
            checks++;
            if (relay !== 1'b1 || (fwd & rev) !== 1'b0) begin
                errors++;
                $display("FAIL timeout_start_m%0d: relay=%b fwd=%b rev=%b required relay=1", m, relay, fwd, rev);
            end
            for (int i = 1; i <= 2000; i++) begin
                tick_ms = 1'b1;
                step();
                tick_ms = 1'b0;
                relay = (m == 0) ? fwd : rev;
                if (i == 1999) begin
                    checks++;
                    if (relay !== 1'b1 || tape_end !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout_early_m%0d: relay=%b tape_end=%b required 1 0", m, relay, tape_end);
                    end
                end
                if (i == 2000) begin
                    checks++;
                    if (relay !== 1'b0 || tape_end !== 1'b1 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout_end_m%0d: relay=%b tape_end=%b busy=%b required 0 1 0",
                                 m, relay, tape_end, busy);
                    end
                end
                step();
            end
            checks++;
            if (tape_end !== 1'b0) begin
                errors++;
                $display("FAIL tape_end_pulse_m%0d: tape_end=%b required 0", m, tape_end);
            end
        end
        start_fwd = 1'b1;
        start_rev = 1'b1;
        step();
        start_fwd = 1'b0;
        start_rev = 1'b0;
        step();
        checks++;
        if (fwd !== 1'b0 || rev !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL both_starts: fwd=%b rev=%b busy=%b required 0 0 0", fwd, rev, busy);
        end
    endtask

    task test_reset_mid();
        int cyc;
        pulse_start_fwd();
        send_frame(5'h03, 10);
        wait_valid(100, cyc);
        photo = 5'h1F;
        repeat (10) step();
        checks++;
        if (frame_valid !== 1'b1 || fwd !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: valid=%b fwd=%b required 1 1", frame_valid, fwd);
        end
        rst = 1'b1;
        photo = 5'b0;
        step();
        checks++;
        if ({fwd, rev, frame_data, frame_valid, stop_seen, tape_end, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required 000000000000",
                     {fwd, rev, frame_data, frame_valid, stop_seen, tape_end, overrun, busy});
        end
        rst = 1'b0;
        step();
        pulse_start_fwd();
        send_frame(5'h06, 10);
        wait_valid(100, cyc);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 5'h06 || fwd !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: valid=%b data=%h fwd=%b required 1 06 1",
                     frame_valid, frame_data, fwd);
        end
        drain();
    endtask

    initial begin
        rst         = 1'b1;
        tick_ms     = 1'b0;
        photo       = 5'b0;
        start_fwd   = 1'b0;
        start_rev   = 1'b0;
        stop        = 1'b0;
        frame_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_stop_code();
        test_overrun();
        test_glitch();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/photo_frame_capture.md
# photo_frame_capture

Downstream consumer of the photo tape reader model. Drives the reader's forward/reverse relay lines, synchronizes and debounces the five photocell outputs (PL6_PHOTO1..5), and assembles each punched frame into a 5-bit code. It then hands the code to the input/typewriter logic over a valid/ready handshake. It also detects the stop code, end of tape (no holes within a timeout) and overrun.

## Interface

- DEB_CLKS, 4: consecutive equal samples needed to change a debounced photocell level.
- GAP_CLKS, 16: consecutive all-low debounced clocks that close a frame.
- TIMEOUT_MS, 2000: tick_ms pulses without a hole before end-of-tape is declared.
- STOP_CODE, 5'h10: frame code that stops forward motion after delivery.

Ports:

- clk  in  1  system clock (9.3 us period); the block is fully synchronous to clk.
- rst  in  1  reset; synchronous, active-high.
- tick_ms  in  1  one-clock pulse per millisecond from timer.
- PL6_PHOTO1..PL6_PHOTO5  in  1 each  raw photocell levels (1 = hole); asynchronous to logic.
- start_fwd  in  1  pulse: begin forward read.
- start_rev  in  1  pulse: begin reverse motion.
- stop  in  1  pulse: stop motion.
- PL6_PHOTO_TAPE_FWD  out  1  forward relay drive.
- PL6_PHOTO_TAPE_REV  out  1  reverse relay drive.
- frame_data  out  5  captured code; bit0 = PHOTO1 … bit4 = PHOTO5.
- frame_valid  out  1  frame_data holds an undelivered frame.
- frame_ready  in  1  consumer accepts the frame.
- stop_seen  out  1  one-clock pulse when STOP_CODE is delivered into the buffer.
- tape_end  out  1  one-clock pulse on timeout.
- overrun  out  1  sticky: a frame completed while the buffer was full.
- busy  out  1  state ≠ IDLE.

## Operation

**Input conditioning**
- Each photocell line passes through a 2-flop synchronizer, then a per-line debouncer.
- The debounced level flips after DEB_CLKS consecutive synchronized samples that differ from it.
- `any_hole` = OR of the five debounced lines.

**States**

IDLE
- FWD=0, REV=0.
- start_fwd → RUN_FWD; also clears overrun and zeroes the timeout counter.
- start_rev → RUN_REV; also zeroes the timeout counter.
- start_fwd and start_rev in the same cycle → ignored, remain IDLE.

RUN_FWD
- FWD=1.
- any_hole → FRAME, with the accumulator loaded from the debounced lines.
- Each tick_ms increments the timeout counter. When it reaches TIMEOUT_MS → IDLE with a tape_end pulse.
- stop → IDLE; stop has priority over all other transitions.

FRAME
- FWD=1.
- Accumulator |= debounced lines every clock.
- Gap counter zeroes on any_hole and increments otherwise.
- When the gap counter reaches GAP_CLKS, the frame completes:
  - Buffer empty, or being emptied this cycle (frame_valid & frame_ready): load frame_data, frame_valid=1.
  - Buffer full: discard the frame, set overrun.
  - Accumulator == STOP_CODE: stop_seen pulses (only if loaded) and next state is IDLE.
  - Otherwise next state is RUN_FWD with the timeout counter zeroed.
- stop → IDLE; the partial frame is discarded.
- No timeout counting in FRAME.

RUN_REV
- REV=1; no frame capture.
- The timeout counter zeroes on any_hole and increments on tick_ms. When it reaches TIMEOUT_MS → IDLE with a tape_end pulse.
- stop → IDLE.

**General rules**
- start_fwd and start_rev are ignored outside IDLE.
- FWD and REV are never both 1.
- Handshake: a transfer occurs on a clock with frame_valid & frame_ready. frame_valid drops on the next clock unless a new frame loads in the same cycle. frame_data is stable while frame_valid=1.
- The timeout counter is 11 bits wide and saturates at TIMEOUT_MS.

## Timing

- Reset values: FWD=0, REV=0, frame_data=0, frame_valid=0, stop_seen=0, tape_end=0, overrun=0, busy=0. Synchronizers, debouncers, counters and accumulator are all zeroed; state=IDLE.
- Reset asserted mid-operation: everything above returns to its reset value on the next clk edge.
- start_fwd at edge N → FWD=1 and busy=1 after edge N+1.
- Raw line rise to debounced rise: 2 + DEB_CLKS clocks.
- Last debounced hole low → frame_valid=1 after GAP_CLKS+1 clocks.
- End-of-frame relay drop for STOP_CODE: FWD=0 on the same edge that sets frame_valid.
- Timeout: FWD (or REV) drops and tape_end pulses on the edge following the TIMEOUT_MS-th tick_ms.
- stop: relays drop one clock after the stop pulse.

## Test plan

1. Reset, start_fwd, photocells present 5'b01101 for 40 clocks then low → FWD=1; frame_valid=1 with frame_data=5'h0D exactly 2+DEB_CLKS+40+GAP_CLKS+1 clocks after the rise (tolerance ±1 per phase); ready=1 clears valid next clock.
2. Frames 5'h03 then 5'h10 with ready=1 → both delivered in order; stop_seen pulses with the second frame; FWD drops on that edge; busy=0.
3. Two frames with ready=0 → first frame held at 5'h03; overrun=1 after the second; frame_data unchanged; next start_fwd clears overrun.
4. Glitch of 2 clocks on PHOTO3 (< DEB_CLKS) while RUN_FWD → no frame, state stays RUN_FWD.
5. start_fwd, no holes, 2000 tick_ms → tape_end pulse, FWD=0; repeat with start_rev → REV=0 and tape_end pulse; start_fwd+start_rev together → no relay.
6. rst asserted during FRAME with frame_valid=1 → all outputs zero on the next edge; a subsequent start_fwd operates normally.
